decryption_cfg_bank: RTL

Parametrised configuration register bank for the decryption top level, successor to the fixed three-key register file. It holds the select value and NUM_CIPHERS cipher keys in shadow registers written over a simple read/write access interface. A commit state machine copies the shadows into the active outputs atomically, and only when the datapath reports idle. It adds a sticky lock, a status register, and range/protocol error checking.

---
 rtl/decryption_cfg_bank.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/decryption_cfg_bank.sv
// Shadow/active configuration bank for the decryption datapath: 1-cycle register access,
// commit copies shadows to active outputs atomically once busy_i drops (deferred while busy).
module decryption_cfg_bank #(
  parameter int ADDR_WIDTH  = 8,
  parameter int REG_WIDTH   = 16,
  parameter int NUM_CIPHERS = 3,
  parameter logic [NUM_CIPHERS*REG_WIDTH-1:0] KEY_RST = {16'h0002, 16'hFFFF, 16'h0000}
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic                             read,
  input  logic                             write,
  input  logic [REG_WIDTH-1:0]             wdata,
  output logic [REG_WIDTH-1:0]             rdata,
  output logic                             done,
  output logic                             error,
  input  logic                             busy_i,
  output logic [REG_WIDTH-1:0]             select,
  output logic [NUM_CIPHERS*REG_WIDTH-1:0] keys,
  output logic                             cfg_valid
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_SELECT  = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CONTROL = ADDR_WIDTH'(8'h02);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = ADDR_WIDTH'(8'h04);
  localparam int                    KEY_BASE     = 16;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [REG_WIDTH-1:0]             shadow_sel;
  logic [NUM_CIPHERS*REG_WIDTH-1:0] shadow_keys;
  logic                             locked;
  logic                             err_flag;

  logic                 req;
  logic                 is_sel, is_ctl, is_sts, is_key;
  logic [2:0]           key_idx;
  logic                 acc_err;
  logic                 wr_ok, rd_ok;
  logic                 commit_req;
  logic                 commit_xfer;
  logic                 err_clr;
  logic [REG_WIDTH-1:0] status_val;
  logic [REG_WIDTH-1:0] rdata_d;

  // Address decode; key registers sit on even addresses from KEY_BASE upward.
  always_comb begin
    is_sel  = (addr == ADDR_SELECT);
    is_ctl  = (addr == ADDR_CONTROL);
    is_sts  = (addr == ADDR_STATUS);
    is_key  = 1'b0;
    key_idx = '0;
    for (int i = 0; i < NUM_CIPHERS; i++) begin
      if (addr == ADDR_WIDTH'(KEY_BASE + 2 * i)) begin
        is_key  = 1'b1;
        key_idx = 3'(i);
      end
    end
  end

  always_comb begin
    req     = read | write;
    acc_err = 1'b0;
    if (req) begin
      if (!(is_sel || is_ctl || is_sts || is_key)) acc_err = 1'b1;
      if (read && write)                           acc_err = 1'b1;
      if (write && is_sts)                         acc_err = 1'b1;
      if (write && (is_sel || is_key) && locked)   acc_err = 1'b1;
      if (write && is_sel && (wdata >= REG_WIDTH'(NUM_CIPHERS))) acc_err = 1'b1;
    end
    wr_ok      = write & ~acc_err;
    rd_ok      = read & ~acc_err;
    commit_req = wr_ok & is_ctl & wdata[1];
    // ERR_CLR takes precedence even when the same access raises an error.
    err_clr    = write & is_ctl & wdata[2];
  end

  always_comb begin
    status_val = {{(REG_WIDTH-3){1'b0}}, err_flag, locked, (state_q == S_WAIT)};
    rdata_d    = '0;
    if (rd_ok) begin
      if (is_sel)      rdata_d = shadow_sel;
      else if (is_sts) rdata_d = status_val;
      else if (is_key) rdata_d = shadow_keys[int'(key_idx) * REG_WIDTH +: REG_WIDTH];
    end
  end

  // Commit FSM: transfer happens on the edge leaving WAIT with busy_i low.
  always_comb begin
    state_d     = state_q;
    commit_xfer = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (commit_req) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!busy_i) begin
          commit_xfer = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata       <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      cfg_valid   <= 1'b0;
      shadow_sel  <= '0;
      shadow_keys <= KEY_RST;
      select      <= '0;
      keys        <= KEY_RST;
      locked      <= 1'b0;
      err_flag    <= 1'b0;
    end else begin
      done      <= req;
      error     <= acc_err;
      rdata     <= rdata_d;
      cfg_valid <= commit_xfer;

      if (wr_ok && is_sel) shadow_sel <= wdata;
      if (wr_ok && is_key) shadow_keys[int'(key_idx) * REG_WIDTH +: REG_WIDTH] <= wdata;
      if (wr_ok && is_ctl && wdata[0]) locked <= 1'b1;

      if (err_clr)      err_flag <= 1'b0;
      else if (acc_err) err_flag <= 1'b1;

      // Active outputs take the pre-edge shadow, so a same-cycle shadow write is not applied.
      if (commit_xfer) begin
        select <= shadow_sel;
        keys   <= shadow_keys;
      end
    end
  end

endmodule
